// File: rtl/alu_seq.sv
// alu_seq: sequential execute-stage ALU with a valid/ready handshake on both sides.
// Every result is registered. DIVU/REMU run an iterative restoring divider that
// produces one quotient bit per cycle. Flags are computed at the selected operand size.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        request handshake; in_ready is high only while idle
//   in_op, in_size             operation code and operand size code (0=8b .. 3=64b)
//   in_a, in_b, in_carry       operands (masked to the size) and carry/borrow input
//   out_valid / out_ready      result handshake; the result is held until it is taken
//   out_result                 result, zero-extended above the size
//   out_zero, out_carry,
//   out_neg, out_div0          result flags
module alu_seq #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned SIZE_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [SIZE_BITS-1:0] in_size,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_zero,
    output logic                 out_carry,
    output logic                 out_neg,
    output logic                 out_div0
);

    // Largest size code that fits the datapath; larger codes fall back to it.
    localparam int unsigned MaxCode = $clog2(WIDTH / 8);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpAdc  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpSbb  = 4'd3;
    localparam logic [3:0] OpCmp  = 4'd4;
    localparam logic [3:0] OpAnd  = 4'd5;
    localparam logic [3:0] OpOr   = 4'd6;
    localparam logic [3:0] OpXor  = 4'd7;
    localparam logic [3:0] OpShl  = 4'd8;
    localparam logic [3:0] OpShr  = 4'd9;
    localparam logic [3:0] OpDivu = 4'd10;
    localparam logic [3:0] OpRemu = 4'd11;

    typedef enum logic [1:0] {StIdle, StDiv, StHold} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic             div0_q, div0_d;

    // Divider state: dividend/quotient shift register, partial remainder, divisor.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       nbits_q, nbits_d;
    logic             is_rem_q, is_rem_d;

    // Bit N-1 of a result, where N is the operand size in bits.
    function automatic logic msb_at(input logic [WIDTH-1:0] r, input logic [7:0] nb);
        logic [WIDTH-1:0] t;
        t = r >> (nb - 8'd1);
        return t[0];
    endfunction

    // ------------------------------------------------------------------
    // Size decode and operand masking
    // ------------------------------------------------------------------
    logic [7:0]       nbits;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;

    always_comb begin
        nbits = 8'(WIDTH);
        if (32'(in_size) <= MaxCode) begin
            nbits = 8'(32'd8 << in_size);
        end
        mask = {WIDTH{1'b1}} >> (8'(WIDTH) - nbits);
        a_m  = in_a & mask;
        b_m  = in_b & mask;
    end

    // ------------------------------------------------------------------
    // Single-cycle execute path (everything except a real division)
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   wide_tmp;
    logic [WIDTH-1:0] sh_tmp;
    logic [7:0]       shamt;
    logic [WIDTH-1:0] acc_res;
    logic             acc_carry;
    logic             acc_div0;
    logic             add_cin;
    logic             sub_cin;
    logic             is_div_op;

    always_comb begin
        acc_res   = '0;
        acc_carry = 1'b0;
        acc_div0  = 1'b0;
        wide_tmp  = '0;
        sh_tmp    = '0;
        add_cin   = (in_op == OpAdc) & in_carry;
        sub_cin   = (in_op == OpSbb) & in_carry;
        is_div_op = (in_op == OpDivu) || (in_op == OpRemu);
        // Operands are masked, so bit N of the (WIDTH+1)-bit sum is the carry out
        // of bit N-1, and bit N of the difference is set exactly when it went negative.
        sum   = {1'b0, a_m} + {1'b0, b_m} + {{WIDTH{1'b0}}, add_cin};
        diff  = {1'b0, a_m} - {1'b0, b_m} - {{WIDTH{1'b0}}, sub_cin};
        shamt = {1'b0, b_m[6:0]} & (nbits - 8'd1);

        case (in_op)
            OpAdd, OpAdc: begin
                acc_res   = sum[WIDTH-1:0];
                wide_tmp  = sum >> nbits;
                acc_carry = wide_tmp[0];
            end
            OpSub, OpSbb, OpCmp: begin
                acc_res   = diff[WIDTH-1:0];
                wide_tmp  = diff >> nbits;
                acc_carry = wide_tmp[0];
            end
            OpAnd: acc_res = a_m & b_m;
            OpOr:  acc_res = a_m | b_m;
            OpXor: acc_res = a_m ^ b_m;
            OpShl: begin
                acc_res = a_m << shamt;
                if (shamt != 8'd0) begin
                    sh_tmp    = a_m >> (nbits - shamt);
                    acc_carry = sh_tmp[0];
                end
            end
            OpShr: begin
                acc_res = a_m >> shamt;
                if (shamt != 8'd0) begin
                    sh_tmp    = a_m >> (shamt - 8'd1);
                    acc_carry = sh_tmp[0];
                end
            end
            // Only reached with b == 0; a nonzero divisor goes to the divider.
            OpDivu: begin
                acc_res  = mask;
                acc_div0 = 1'b1;
            end
            OpRemu: begin
                acc_res  = a_m;
                acc_div0 = 1'b1;
            end
            default: acc_res = '0;
        endcase
        acc_res = acc_res & mask;
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;
    logic             qbit;

    always_comb begin
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        qbit   = ~trial[WIDTH];
        rem_nx = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        // Quotient bits enter at the bottom as the left-aligned dividend leaves the top.
        dvd_nx = {dvd_q[WIDTH-2:0], qbit};
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        nbits_d  = nbits_q;
        is_rem_d = is_rem_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_div_op && (b_m != '0)) begin
                        state_d  = StDiv;
                        dvd_d    = a_m << (8'(WIDTH) - nbits);
                        rem_d    = '0;
                        dvs_d    = b_m;
                        cnt_d    = nbits;
                        nbits_d  = nbits;
                        is_rem_d = (in_op == OpRemu);
                    end else begin
                        state_d  = StHold;
                        // CMP reports flags of the difference but returns zero.
                        result_d = (in_op == OpCmp) ? '0 : acc_res;
                        zero_d   = (acc_res == '0);
                        neg_d    = msb_at(acc_res, nbits);
                        carry_d  = acc_carry;
                        div0_d   = acc_div0;
                    end
                end
            end
            StDiv: begin
                dvd_d = dvd_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d  = StHold;
                    result_d = is_rem_q ? rem_nx : dvd_nx;
                    zero_d   = is_rem_q ? (rem_nx == '0) : (dvd_nx == '0);
                    neg_d    = msb_at(is_rem_q ? rem_nx : dvd_nx, nbits_q);
                    carry_d  = 1'b0;
                    div0_d   = 1'b0;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            dvd_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            nbits_q  <= '0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            nbits_q  <= nbits_d;
            is_rem_q <= is_rem_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StHold);
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_carry  = carry_q;
    assign out_neg    = neg_q;
    assign out_div0   = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=64). Stimulus is a linear list of steps;
// every expected value is hand-computed.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [1:0]  in_size;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_zero;
    logic        out_carry;
    logic        out_neg;
    logic        out_div0;

    int checks = 0;
    int errors = 0;
    int lat;

    alu_seq #(.WIDTH(64), .SIZE_BITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_size    (in_size),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_neg    (out_neg),
        .out_div0   (out_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle, then count edges until out_valid (bounded).
    // The accept edge counts as cycle 1.
    task automatic issue(input logic [3:0] op, input logic [1:0] size, input logic [63:0] a,
                         input logic [63:0] b, input logic cin, output int latency);
        in_op    = op;
        in_size  = size;
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = '1;
        in_b     = '1;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic check_out(input string tag, input logic [63:0] res, input logic z,
                             input logic c, input logic n, input logic d0);
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".result"}, out_result, res);
        check({tag, ".zero"}, {63'd0, out_zero}, {63'd0, z});
        check({tag, ".carry"}, {63'd0, out_carry}, {63'd0, c});
        check({tag, ".neg"}, {63'd0, out_neg}, {63'd0, n});
        check({tag, ".div0"}, {63'd0, out_div0}, {63'd0, d0});
    endtask

    // Consume the held result and confirm the block is idle again next cycle.
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".ready_after"}, {63'd0, in_ready}, 64'd1);
        check({tag, ".valid_after"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_size   = '0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", {63'd0, in_ready}, 64'd1);
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.result", out_result, 64'd0);
        check("rst.flags", {60'd0, out_zero, out_carry, out_neg, out_div0}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 8-bit overflow to zero
        issue(4'd0, 2'd0, 64'hFF, 64'h01, 1'b0, lat);
        check("add8.lat", 64'(lat), 64'd1);
        check_out("add8", 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        take("add8");

        // SUB 32-bit borrow, upper bits stay zero
        issue(4'd2, 2'd2, 64'h1, 64'h2, 1'b0, lat);
        check("sub32.lat", 64'(lat), 64'd1);
        check_out("sub32", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        take("sub32");

        // DIVU / REMU 64-bit: N+1 = 65 cycles
        issue(4'd10, 2'd3, 64'd100, 64'd7, 1'b0, lat);
        check("divu64.lat", 64'(lat), 64'd65);
        check_out("divu64", 64'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        take("divu64");
        issue(4'd11, 2'd3, 64'd100, 64'd7, 1'b0, lat);
        check("remu64.lat", 64'(lat), 64'd65);
        check_out("remu64", 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        take("remu64");

        // DIVU / REMU 8-bit: 200/7 = 28 r 4, 9 cycles
        issue(4'd10, 2'd0, 64'hFFFF_FF00_0000_00C8, 64'd7, 1'b0, lat);
        check("divu8.lat", 64'(lat), 64'd9);
        check_out("divu8", 64'd28, 1'b0, 1'b0, 1'b0, 1'b0);
        take("divu8");
        issue(4'd11, 2'd0, 64'd200, 64'd7, 1'b0, lat);
        check_out("remu8", 64'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        take("remu8");

        // Divide by zero at 16 bits: one cycle
        issue(4'd10, 2'd1, 64'h1234, 64'h0, 1'b0, lat);
        check("div0.lat", 64'(lat), 64'd1);
        check_out("div0", 64'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        take("div0");
        issue(4'd11, 2'd1, 64'h1234, 64'hABCD_0000, 1'b0, lat);
        check("rem0.lat", 64'(lat), 64'd1);
        check_out("rem0", 64'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        take("rem0");

        // Shifts: amount is b mod N, carry is the last bit shifted out
        issue(4'd8, 2'd0, 64'h81, 64'd9, 1'b0, lat);
        check_out("shl8", 64'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        take("shl8");
        issue(4'd9, 2'd1, 64'h0003, 64'h11, 1'b0, lat);
        check_out("shr16", 64'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        take("shr16");
        issue(4'd8, 2'd0, 64'h80, 64'd8, 1'b0, lat);
        check_out("shl8_amt0", 64'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        take("shl8_amt0");

        // CMP: result forced to zero, flags from the difference
        issue(4'd4, 2'd0, 64'd5, 64'd5, 1'b0, lat);
        check_out("cmp_eq", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        take("cmp_eq");
        issue(4'd4, 2'd0, 64'd3, 64'd5, 1'b0, lat);
        check_out("cmp_lt", 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        take("cmp_lt");

        // ADC / SBB with carry-in
        issue(4'd1, 2'd0, 64'hFE, 64'h01, 1'b1, lat);
        check_out("adc8", 64'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        take("adc8");
        issue(4'd3, 2'd0, 64'h00, 64'h00, 1'b1, lat);
        check_out("sbb8", 64'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        take("sbb8");

        // XOR with operand bits above the size masked off
        issue(4'd7, 2'd0, 64'hFFFF_00F0, 64'h0F, 1'b0, lat);
        check_out("xor8", 64'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        take("xor8");

        // Illegal op code
        issue(4'd12, 2'd3, 64'h1234, 64'h5678, 1'b1, lat);
        check("illegal.lat", 64'(lat), 64'd1);
        check_out("illegal", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        take("illegal");

        // Backpressure: result held while out_ready is low
        issue(4'd0, 2'd2, 64'h7FFF_FFFF, 64'h1, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            check_out("bp", 64'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
            check("bp.in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        take("bp");

        // Reset in the middle of a 64-bit division
        in_op    = 4'd10;
        in_size  = 2'd3;
        in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b     = 64'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("middiv.busy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #2;
        check("middiv.valid", {63'd0, out_valid}, 64'd0);
        check("middiv.ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("middiv.ready_next", {63'd0, in_ready}, 64'd1);
        check("middiv.result", out_result, 64'd0);
        repeat (70) begin
            @(posedge clk);
            #1;
            check("middiv.no_stray", {63'd0, out_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
